// File: rtl/light_pattern_seq.sv
// light_pattern_seq: drives the light-dance shift/load stage.
// Turns a selected lighting pattern into passes of one parallel-load step
// followed by eight LSB-first serial-shift steps, each marked by a one-cycle
// `step` strobe. Step rate, repeat count and abort are runtime-controlled.
// Optional feature macro: LIGHTSEQ_USER_PATTERN_EN adds the `user_pattern`
// port and makes mode 3 use it as seed (word = ~seed). Without the macro,
// mode 3 behaves like mode 0.
module light_pattern_seq #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [PRESCALE_W-1:0] step_div,
  input  logic [3:0]            repeat_cnt,
`ifdef LIGHTSEQ_USER_PATTERN_EN
  input  logic [7:0]            user_pattern,
`endif
  output logic                  step,
  output logic                  load,
  output logic                  din,
  output logic [7:0]            pdata,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [3:0]            rep_q, rep_d;
  logic [3:0]            pass_q, pass_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            word_q, word_d;
  logic                  step_d, load_d, din_d, busy_d, done_d;
  logic [7:0]            pdata_d;

  logic [7:0]            sel_seed, sel_word;
  logic                  expiry;
  logic                  last_pass;

  // Pattern table: seed for the load step and the word shifted out LSB first.
  always_comb begin
    sel_seed = 8'h80;
    sel_word = 8'h00;
    case (mode)
      2'd1: begin sel_seed = 8'hF0; sel_word = 8'h0F; end
      2'd2: begin sel_seed = 8'hAA; sel_word = 8'h55; end
`ifdef LIGHTSEQ_USER_PATTERN_EN
      2'd3: begin sel_seed = user_pattern; sel_word = ~user_pattern; end
`endif
      default: ;
    endcase
  end

  // The prescaler runs 0..div-1; the step fires on the div-th cycle.
  assign expiry = (presc_q == div_q - PRESCALE_W'(1));

  // A pass ends the sequence only for a finite repeat count that is reached.
  assign last_pass = (rep_q != 4'd0) &&
                     (({1'b0, pass_q} + 5'd1) >= {1'b0, rep_q});

  // Next-state and next-output logic; stop beats expiry beats start.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_d = state_q;
    presc_d = presc_q;
    div_d   = div_q;
    rep_d   = rep_q;
    pass_d  = pass_q;
    bit_d   = bit_q;
    word_d  = word_q;
    pdata_d = pdata;
    din_d   = din;
    busy_d  = busy;
    step_d  = 1'b0;
    load_d  = 1'b0;
    done_d  = 1'b0;

    if (state_q != IDLE && stop) begin
      // Abort: no further strobe, no done; pdata keeps the current seed.
      state_d = IDLE;
      busy_d  = 1'b0;
      din_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !stop) begin
            state_d = LOAD;
            div_d   = (step_div == '0) ? PRESCALE_W'(1) : step_div;
            rep_d   = repeat_cnt;
            word_d  = sel_word;
            pdata_d = sel_seed;
            presc_d = '0;
            pass_d  = 4'd0;
            bit_d   = 3'd0;
            busy_d  = 1'b1;
          end
        end
        LOAD: begin
          if (expiry) begin
            presc_d = '0;
            step_d  = 1'b1;
            load_d  = 1'b1;
            bit_d   = 3'd0;
            state_d = SHIFT;
          end else begin
            presc_d = presc_q + PRESCALE_W'(1);
          end
        end
        SHIFT: begin
          if (expiry) begin
            presc_d = '0;
            step_d  = 1'b1;
            din_d   = word_q[bit_q];
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              // Saturate so continuous mode never wraps the pass count.
              pass_d  = (pass_q == 4'hF) ? pass_q : pass_q + 4'd1;
              state_d = last_pass ? FIN : LOAD;
            end
          end else begin
            presc_d = presc_q + PRESCALE_W'(1);
          end
        end
        FIN: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= IDLE;
      presc_q <= '0;
      div_q   <= PRESCALE_W'(1);
      rep_q   <= 4'd0;
      pass_q  <= 4'd0;
      bit_q   <= 3'd0;
      word_q  <= 8'h00;
      pdata   <= 8'h00;
      din     <= 1'b0;
      busy    <= 1'b0;
      step    <= 1'b0;
      load    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      rep_q   <= rep_d;
      pass_q  <= pass_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      pdata   <= pdata_d;
      din     <= din_d;
      busy    <= busy_d;
      step    <= step_d;
      load    <= load_d;
      done    <= done_d;
    end
  end

endmodule

// File: doc/light_pattern_seq.md
# light_pattern_seq

Upstream driver for the light-dance shift/load stage. It turns a selected lighting pattern into a timed sequence of one parallel-load step followed by eight serial-shift steps, presenting `pdata`, `load` and `din` with a `step` strobe. The strobe tells the downstream stage when to sample. Repeat count, step rate and abort are runtime-controlled from the home controller.

## Interface
- `PRESCALE_W`, default 16: width of the step-rate divider.
- `clk`  in  1  system clock, all state on rising edge.
- `arst`  in  1  asynchronous active-low reset.
- `start`  in  1  level sampled each cycle; begins a sequence when idle.
- `stop`  in  1  abort; returns to idle.
- `mode`  in  2  pattern select, captured at start.
- `step_div`  in  PRESCALE_W  clocks per step, captured at start; 0 is treated as 1.
- `repeat_cnt`  in  4  passes to run, captured at start; 0 means continuous until `stop`.
- `user_pattern`  in  8  seed for mode 3; present only with `LIGHTSEQ_USER_PATTERN_EN`.
- `step`  out  1  one-cycle strobe; downstream acts on load/din/pdata this cycle.
- `load`  out  1  high only in a load step.
- `din`  out  1  serial bit for a shift step.
- `pdata`  out  8  parallel seed for the current sequence.
- `busy`  out  1  high from the cycle after an accepted start until return to IDLE.
- `done`  out  1  one-cycle pulse on normal completion.

## Operation
- Pattern table (seed / din word): mode 0 = 8'h80 / 8'h00; mode 1 = 8'hF0 / 8'h0F; mode 2 = 8'hAA / 8'h55; mode 3 = `user_pattern` / ~`user_pattern`.
- Shift step i (i = 0..7) drives din = word[i], LSB first.
- Pass = 1 load step + 8 shift steps = 9 steps.
- States:
  - IDLE: start=1 and stop=0 → capture mode, seed, word, div_eff, repeat; clear prescaler and pass counter; → LOAD.
  - LOAD: on prescaler expiry, issue step with load=1 and pdata=seed; bit_idx=0; → SHIFT.
  - SHIFT: each expiry, issue step with load=0 and din=word[bit_idx]; bit_idx++.
  - After bit_idx 7: pass counter increments. If repeat=0 or passes < repeat → LOAD, else → DONE.
  - DONE: done=1 for one cycle; → IDLE.
- `stop` in any non-IDLE state → IDLE at the next edge. No further step; done not asserted; din and load cleared; pdata holds.
- Priority: stop > expiry > start. start while busy is ignored. start and stop together in IDLE → stays IDLE.
- Inputs are captured only at start. Changes to mode, step_div, repeat_cnt or user_pattern mid-sequence have no effect.
- Pass counter is 4 bits and saturates in continuous mode; it never wraps into a spurious terminal match.

## Timing
- Reset values (async, while arst=0): step=0, load=0, din=0, pdata=8'h00, busy=0, done=0; state IDLE; counters 0.
- All outputs are registered.
- First step (the load step) is high exactly div_eff cycles after the edge that samples start. Subsequent steps follow every div_eff cycles.
- div_eff=1: step high every cycle while running.
- load and din are valid only in cycles where step=1. Between steps, load=0 and din holds its last value.
- pdata is updated at the start edge and held until the next accepted start.
- done is high in the cycle after the final shift step. busy falls in the same cycle done rises.
- Finite run length: 9·div_eff·repeat cycles from start to the final step.
- Reset mid-sequence: immediate return to reset values; no strobe is completed.

## Configuration
- `LIGHTSEQ_USER_PATTERN_EN` defined: `user_pattern` port exists; mode 3 uses it as described above.
- Not defined: port absent; mode 3 behaves identically to mode 0 (seed 8'h80, word 8'h00).

## Test plan
- Reset: hold arst=0 with random inputs → all outputs 0; release with start=0 → outputs stay 0, busy=0.
- mode 1, div=1, repeat=1, start pulse → step every cycle.
  - Step 1: load=1, pdata=8'hF0.
  - Steps 2–9: din = 1,1,1,1,0,0,0,0.
  - done one cycle after step 9; busy low thereafter.
- mode 2, div=4, repeat=2 → 18 steps spaced exactly 4 cycles apart; load at step 1 and step 10; din pattern 1,0,1,0,… each pass; single done.
- repeat=0, div=0 (treated as 1), mode 0 → continuous 9-step passes. stop asserted mid-SHIFT → no step the next cycle; busy=0; done never pulses.
- Simultaneous events:
  - start while busy → ignored; pass count unchanged.
  - stop coincident with an expiry → that step is suppressed.
  - start+stop in IDLE → stays idle.
- Macro on: mode 3, user_pattern=8'h3C → load pdata=8'h3C; din = 1,1,0,0,0,0,1,1.
- Macro off: mode 3 → pdata=8'h80; din all 0.
